// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_ctrl
// Purpose  : Multiplexed N-digit 7-segment display controller. Bytes arrive
//            as a strobe plus data and are shown either as two hex digits
//            shifted into the digit buffer, or as an unsigned decimal value
//            produced by a sequential double-dabble converter. Digits are
//            scanned one at a time onto a shared segment bus.
// Options  : define SEG_LZB_EN to blank leading zeros on every buffer update.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 25000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_byte_dv,
  input  logic [7:0]            i_byte,
  input  logic                  i_mode,
  output logic [6:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_dig_en,
  output logic                  o_busy,
  output logic                  o_overrun
);

  // Parameter legality is enforced at elaboration time.
  if ((NUM_DIGITS < 4) || (NUM_DIGITS > 8) || ((NUM_DIGITS % 2) != 0)) begin : g_bad_digits
    $error("seg_display_ctrl: NUM_DIGITS must be an even value in 4..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg_display_ctrl: SCAN_DIV must be >= 2");
  end

  localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IDX_W = $clog2(NUM_DIGITS);
  localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]    c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_DIG_ONE = NUM_DIGITS'(1);
  localparam logic [6:0]            c_SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] c_DIG_POL = {NUM_DIGITS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Active-high segment pattern (abcdefg) for one buffer entry.
  function automatic logic [6:0] f_seg(input logic [3:0] v, input logic blank);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return blank ? 7'b0000000 : s;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept_hex;
  logic                    w_accept_dec;
  logic                    w_commit;
  logic                    w_drop;

  // Double-dabble shift register: [19:8] BCD (hundreds/tens/units), [7:0] binary.
  logic [19:0]             r_sh;
  logic [19:0]             w_sh_adj;
  logic [2:0]              r_bit_cnt;

  logic [3:0]              r_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [3:0]              w_val_nxt [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank_nxt;
  logic                    w_buf_we;

  logic [c_CNT_W-1:0]      r_scan_cnt;
  logic [c_IDX_W-1:0]      r_scan_idx;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_en;
  logic                    r_overrun;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept_hex = 1'b0;
    w_accept_dec = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_byte_dv) begin
          if (i_mode) begin
            w_accept_dec = 1'b1;
            w_state_nxt  = S_CONV;
          end else begin
            w_accept_hex = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (r_bit_cnt == 3'd7) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);
  assign w_drop = i_byte_dv && o_busy;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    w_sh_adj = r_sh;
    for (int n = 0; n < 3; n++) begin
      if (r_sh[8+4*n +: 4] >= 4'd5) w_sh_adj[8+4*n +: 4] = r_sh[8+4*n +: 4] + 4'd3;
    end
  end

  // Converter datapath: load on accept, shift one bit per CONV cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept_dec) begin
      r_sh      <= {12'd0, i_byte};
      r_bit_cnt <= '0;
    end else if (r_state == S_CONV) begin
      r_sh      <= w_sh_adj << 1;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Next digit-buffer contents for a hex shift or a decimal commit.
  always_comb begin
    w_buf_we = w_accept_hex || w_commit;
    for (int i = 0; i < NUM_DIGITS; i++) w_val_nxt[i] = r_val[i];
    if (w_accept_hex) begin
      for (int i = 2; i < NUM_DIGITS; i++) w_val_nxt[i] = r_val[i-2];
      w_val_nxt[1] = i_byte[7:4];
      w_val_nxt[0] = i_byte[3:0];
    end else if (w_commit) begin
      for (int i = 3; i < NUM_DIGITS; i++) w_val_nxt[i] = 4'd0;
      w_val_nxt[2] = r_sh[19:16];
      w_val_nxt[1] = r_sh[15:12];
      w_val_nxt[0] = r_sh[11:8];
    end
  end

`ifdef SEG_LZB_EN
  // Blank every digit above the most significant nonzero one; digit0 always shows.
  always_comb begin
    logic w_seen;
    w_seen      = 1'b0;
    w_blank_nxt = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_seen         = w_seen | (w_val_nxt[i] != 4'd0);
      w_blank_nxt[i] = ~w_seen;
    end
  end
`else
  assign w_blank_nxt = '0;
`endif

  // Digit buffer: cleared on reset, written on hex accept or decimal commit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_val[i] <= 4'd0;
      r_blank <= '0;
    end else if (w_buf_we) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_val[i] <= w_val_nxt[i];
      r_blank <= w_blank_nxt;
    end
  end

  // Scan timing: each digit holds for SCAN_DIV cycles, index wraps at the last digit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == c_CNT_MAX) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == c_IDX_MAX) ? '0 : r_scan_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Registered pin drivers; reset preloads digit 0 so the bus is never all-off afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seg    <= f_seg(4'd0, 1'b0) ^ c_SEG_POL;
      r_dig_en <= c_DIG_ONE ^ c_DIG_POL;
    end else begin
      r_seg    <= f_seg(r_val[r_scan_idx], r_blank[r_scan_idx]) ^ c_SEG_POL;
      r_dig_en <= (c_DIG_ONE << r_scan_idx) ^ c_DIG_POL;
    end
  end

  // Overrun flag: one-cycle pulse after a strobe arrives while busy.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_overrun <= 1'b0;
    else         r_overrun <= w_drop;
  end

  // The display is dark for as long as reset is held.
  assign o_seg     = i_reset ? c_SEG_POL : r_seg;
  assign o_dig_en  = i_reset ? c_DIG_POL : r_dig_en;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised multiplexed 7-segment display controller for N digits. It accepts bytes from the UART receiver as a data-valid strobe plus byte. The byte is shown either as hex (shifted into a digit buffer, two digits per byte) or as unsigned decimal, using a sequential double-dabble converter. The block scans the digits time-multiplexed onto one shared segment bus with per-digit enables, and sits between uart_rx and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits; legal even values 4..8; elaboration error otherwise.
SCAN_DIV, 25000, clock cycles each digit is enabled per scan slot; must be >= 2.
ACTIVE_LOW, 1, 1 = o_seg and o_dig_en driven low when lit/enabled; 0 = active-high.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_byte_dv  in  1  one-cycle strobe: i_byte valid
i_byte  in  8  received byte
i_mode  in  1  sampled with i_byte_dv: 0 = hex, 1 = decimal
o_seg  out  7  segments; bit6 = a ... bit0 = g; polarity per ACTIVE_LOW
o_dig_en  out  NUM_DIGITS  one-hot digit enable; bit0 = rightmost digit; polarity per ACTIVE_LOW
o_busy  out  1  decimal conversion in progress
o_overrun  out  1  one-cycle pulse: byte dropped

Behaviour:
- One clock, i_clk; reset is synchronous and active-high on i_reset.
- Digit buffer: NUM_DIGITS entries, each 4-bit value plus blank flag.
- Reset state: all entries value 0, not blank; FSM IDLE; scan counter 0; scan index 0; o_busy 0; o_overrun 0.
- While i_reset is high: o_seg all unlit and o_dig_en all disabled.
- Hex mode: i_byte_dv with i_mode=0 in IDLE -> next cycle the buffer shifts up by two digits (top two discarded).
  - digit1 = i_byte[7:4], digit0 = i_byte[3:0]; blank flags cleared. o_busy stays 0.
- Decimal mode FSM: IDLE -> CONV -> COMMIT -> IDLE.
  - i_byte_dv with i_mode=1 in IDLE loads the shift register and enters CONV.
  - CONV runs exactly 8 cycles of add-3-then-shift double-dabble.
  - COMMIT, 1 cycle: digit2/1/0 = hundreds/tens/units; all higher digits = value 0.
  - o_busy is high for exactly 9 cycles (all of CONV and COMMIT). The buffer shows the new value from the cycle after COMMIT.
- i_byte_dv while o_busy=1: byte dropped, buffer and conversion unaffected, o_overrun pulses high for 1 cycle on the next cycle.
- Mode is latched per byte. Switching i_mode without a strobe changes nothing.
- Scan counter runs 0..SCAN_DIV-1. On wrap, the scan index advances (index NUM_DIGITS-1 wraps to 0).
- o_seg and o_dig_en are registered: 1-cycle latency from scan index and buffer. o_dig_en is exactly one-hot, never all-off outside reset.
- Segment code, active-high before polarity, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - blank flag set -> 0000000
- ACTIVE_LOW=1 inverts both o_seg and o_dig_en.
- Reset mid-conversion: aborts, buffer zeroed, o_busy 0 the next cycle.

Optional Feature:
- Macro SEG_LZB_EN (leading-zero blanking).
- Defined: on every buffer update, digits above the most significant nonzero digit have their blank flag set. Digit0 is never blanked, so decimal 7 shows "   7" and hex 0x05 after reset shows "   5".
- Undefined: blank flags are always 0, so decimal 7 shows "0007" and hex 0x05 shows "0005".

Test Plan:
1. Reset, SCAN_DIV=4, ACTIVE_LOW=0 -> o_dig_en 0001, 0010, 0100, 1000 each for 4 cycles, then repeat; o_seg=1111110 on every digit.
2. Hex 0xA5 then 0x3C, NUM_DIGITS=4 -> scan shows digit3..0 = A,5,3,C; digit0 o_seg=1001110.
3. Decimal 0xFF -> o_busy high exactly 9 cycles; digits show 0,2,5,5; with SEG_LZB_EN digit3 blank (0000000).
4. Decimal 0x07, then a second i_byte_dv 3 cycles later -> o_overrun 1-cycle pulse; final display 0007 (or "   7" with SEG_LZB_EN); second byte ignored.
5. Assert i_reset during CONV cycle 4 of decimal 0x80 -> o_busy 0 next cycle; display returns to 0000; no overrun pulse.
6. ACTIVE_LOW=1, hex 0x88 -> the enabled digit's o_dig_en bit is 0 and the others are 1; o_seg=0000000 on digits 0 and 1.
